// File: rtl/hardware_heap_arbiter_if.sv
// rtl/hardware_heap_arbiter_if.sv - requester, response and RAM port bundle for the heap arbiter
interface hardware_heap_arbiter_if;
    logic        req0_valid;
    logic        req0_we;
    logic [29:0] req0_addr;
    logic [63:0] req0_wdata;
    logic        req0_ready;
    logic        req1_valid;
    logic        req1_we;
    logic [29:0] req1_addr;
    logic [63:0] req1_wdata;
    logic        req1_ready;
    logic        rsp0_valid;
    logic [63:0] rsp0_data;
    logic        rsp1_valid;
    logic [63:0] rsp1_data;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/hardware_heap_arbiter.sv
// rtl/hardware_heap_arbiter.sv - two-port round-robin heap RAM arbiter; HEAP_ARB_BOUNDS_CHECK_EN adds bounds checking and err
module hardware_heap_arbiter #(
    parameter int DEPTH = 1280
) (
    input  logic system1000,
    input  logic system1000_rst,
`ifdef HEAP_ARB_BOUNDS_CHECK_EN
    output logic err,
`endif
    hardware_heap_arbiter_if.slave bus
);

`ifdef HEAP_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic        prio;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        grant_idx;
    logic        sel_we;
    logic [29:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        oob;

    logic        ram_we_q;
    logic [29:0] ram_addr_q;
    logic [63:0] ram_wdata_q;

    // Read tracking: stage 1 = command on RAM port, stage 2 = ram_rdata valid
    logic        s1_valid;
    logic        s1_owner;
    logic        s1_oob;
    logic        s2_valid;
    logic        s2_owner;
    logic        s2_oob;

    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
        grant1 = bus.req1_valid && (!bus.req0_valid || prio);
    end

    assign accept     = grant0 | grant1;
    assign grant_idx  = grant1;
    assign sel_we     = grant1 ? bus.req1_we    : bus.req0_we;
    assign sel_addr   = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata  = grant1 ? bus.req1_wdata : bus.req0_wdata;
    assign oob        = BOUNDS_EN && (sel_addr >= DEPTH_W);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            prio        <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            s1_valid    <= 1'b0;
            s1_owner    <= 1'b0;
            s1_oob      <= 1'b0;
            s2_valid    <= 1'b0;
            s2_owner    <= 1'b0;
            s2_oob      <= 1'b0;
        end else begin
            if (accept) begin
                prio        <= ~grant_idx;
                ram_we_q    <= sel_we && !oob;
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_wdata;
            end else begin
                ram_we_q    <= 1'b0;
            end
            s1_valid <= accept && !sel_we;
            s1_owner <= grant_idx;
            s1_oob   <= oob;
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            s2_oob   <= s1_oob;
        end
    end

`ifdef HEAP_ARB_BOUNDS_CHECK_EN
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            err <= 1'b0;
        end else if (accept && oob) begin
            err <= 1'b1;
        end
    end
`endif

    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;

    // Rejected out-of-range reads return zero instead of whatever the RAM produced
    assign bus.rsp0_valid = s2_valid && !s2_owner;
    assign bus.rsp1_valid = s2_valid && s2_owner;
    assign bus.rsp0_data  = s2_oob ? 64'd0 : bus.ram_rdata;
    assign bus.rsp1_data  = s2_oob ? 64'd0 : bus.ram_rdata;

endmodule

// File: tb/tb_hardware_heap_arbiter.sv
// tb/tb_hardware_heap_arbiter.sv - directed self-checking bench for hardware_heap_arbiter
module tb_hardware_heap_arbiter;
    logic system1000;
    logic system1000_rst;
`ifdef HEAP_ARB_BOUNDS_CHECK_EN
    logic err;
`endif
    int n_checks;
    int n_fails;
    logic [63:0] mem [0:2047];

    hardware_heap_arbiter_if bus ();

    hardware_heap_arbiter #(.DEPTH(1280)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
`ifdef HEAP_ARB_BOUNDS_CHECK_EN
        .err            (err),
`endif
        .bus            (bus)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    // Registered-output RAM, 1-cycle read latency, read-before-write on same edge
    always @(posedge system1000) begin
        if (bus.ram_we) mem[bus.ram_addr[10:0]] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr[10:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge system1000);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 64'(i) ^ 64'hA5A5_0000_0000_0000;
        mem[3]    = 64'h1234;
        mem[20]   = 64'hAAAA_0020;
        mem[21]   = 64'hBBBB_0021;
        mem[1300] = 64'hFFFF_FFFF;
        bus.ram_rdata = '0;
        idle_inputs();
        system1000_rst = 1'b1;
        next_cycle(); next_cycle();
        #1;
        check("reset_ram_we",    {63'd0, bus.ram_we},     64'd0);
        check("reset_ram_addr",  {34'd0, bus.ram_addr},   64'd0);
        check("reset_ram_wdata", bus.ram_wdata,           64'd0);
        check("reset_rsp0",      {63'd0, bus.rsp0_valid}, 64'd0);
        check("reset_rsp1",      {63'd0, bus.rsp1_valid}, 64'd0);
`ifdef HEAP_ARB_BOUNDS_CHECK_EN
        check("reset_err",       {63'd0, err},            64'd0);
`endif
        system1000_rst = 1'b0;

        // Single requester read of preloaded word 3 (prio -> 1)
        next_cycle();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 30'd3;
        #1;
        check("single_ready0", {63'd0, bus.req0_ready}, 64'd1);
        check("single_ready1", {63'd0, bus.req1_ready}, 64'd0);
        next_cycle(); idle_inputs(); #1;
        check("single_ram_we",   {63'd0, bus.ram_we},   64'd0);
        check("single_ram_addr", {34'd0, bus.ram_addr}, 64'd3);
        check("single_rsp_early", {63'd0, bus.rsp0_valid}, 64'd0);
        next_cycle(); #1;
        check("single_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
        check("single_rsp0_data",  bus.rsp0_data,           64'h1234);
        check("single_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
        next_cycle(); #1;
        check("single_rsp0_once",  {63'd0, bus.rsp0_valid}, 64'd0);

        // Write then read-after-write on req1 (prio ends at 0)
        next_cycle();
        bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 30'd10; bus.req1_wdata = 64'hDEAD;
        #1;
        check("wr_ready1", {63'd0, bus.req1_ready}, 64'd1);
        next_cycle();
        bus.req1_we = 1'b0; bus.req1_wdata = '0;
        #1;
        check("rd_ready1",    {63'd0, bus.req1_ready}, 64'd1);
        check("wr_ram_we",    {63'd0, bus.ram_we},     64'd1);
        check("wr_ram_addr",  {34'd0, bus.ram_addr},   64'd10);
        check("wr_ram_wdata", bus.ram_wdata,           64'hDEAD);
        next_cycle(); idle_inputs(); #1;
        check("wr_no_rsp0", {63'd0, bus.rsp0_valid}, 64'd0);
        check("wr_no_rsp1", {63'd0, bus.rsp1_valid}, 64'd0);
        next_cycle(); #1;
        check("raw_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd1);
        check("raw_rsp1_data",  bus.rsp1_data,           64'hDEAD);
        check("raw_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);

        // Idle for 5 cycles
        for (int k = 0; k < 5; k++) begin
            next_cycle(); #1;
            check("idle_ram_we", {63'd0, bus.ram_we},     64'd0);
            check("idle_rsp0",   {63'd0, bus.rsp0_valid}, 64'd0);
            check("idle_rsp1",   {63'd0, bus.rsp1_valid}, 64'd0);
        end

        // Contention: both valid for 6 cycles, prio still 0 after idle
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            bus.req0_valid = (k < 6); bus.req0_we = 1'b0; bus.req0_addr = 30'd20;
            bus.req1_valid = (k < 6); bus.req1_we = 1'b0; bus.req1_addr = 30'd21;
            #1;
            if (k < 6) begin
                check("cont_ready0", {63'd0, bus.req0_ready}, {63'd0, (k % 2) == 0});
                check("cont_ready1", {63'd0, bus.req1_ready}, {63'd0, (k % 2) == 1});
            end
            if (k >= 2) begin
                check("cont_rsp0_valid", {63'd0, bus.rsp0_valid}, {63'd0, (k % 2) == 0});
                check("cont_rsp1_valid", {63'd0, bus.rsp1_valid}, {63'd0, (k % 2) == 1});
                if ((k % 2) == 0) check("cont_rsp0_data", bus.rsp0_data, 64'hAAAA_0020);
                else              check("cont_rsp1_data", bus.rsp1_data, 64'hBBBB_0021);
            end
        end
        idle_inputs();

        // Reset with a read in flight (prio -> 1 before reset)
        next_cycle();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 30'd3;
        #1;
        check("mid_ready0", {63'd0, bus.req0_ready}, 64'd1);
        next_cycle(); idle_inputs();
        system1000_rst = 1'b1;
        #1;
        check("mid_rst_ram_we",    {63'd0, bus.ram_we},     64'd0);
        check("mid_rst_ram_addr",  {34'd0, bus.ram_addr},   64'd0);
        check("mid_rst_ram_wdata", bus.ram_wdata,           64'd0);
        check("mid_rst_rsp0",      {63'd0, bus.rsp0_valid}, 64'd0);
        check("mid_rst_rsp1",      {63'd0, bus.rsp1_valid}, 64'd0);
        next_cycle();
        system1000_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            check("post_rst_no_rsp0", {63'd0, bus.rsp0_valid}, 64'd0);
        end
        next_cycle();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("post_rst_prio_ready0", {63'd0, bus.req0_ready}, 64'd1);
        check("post_rst_prio_ready1", {63'd0, bus.req1_ready}, 64'd0);
        next_cycle(); idle_inputs();
        next_cycle(); next_cycle(); next_cycle();

`ifdef HEAP_ARB_BOUNDS_CHECK_EN
        next_cycle();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 30'd1280; bus.req0_wdata = 64'h55;
        #1;
        check("oob_wr_ready0", {63'd0, bus.req0_ready}, 64'd1);
        next_cycle();
        bus.req0_we = 1'b0; bus.req0_addr = 30'd1300; bus.req0_wdata = '0;
        #1;
        check("oob_wr_ram_we", {63'd0, bus.ram_we}, 64'd0);
        check("oob_err_set",   {63'd0, err},        64'd1);
        check("oob_rd_ready0", {63'd0, bus.req0_ready}, 64'd1);
        next_cycle(); idle_inputs();
        next_cycle(); #1;
        check("oob_rd_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
        check("oob_rd_rsp0_data",  bus.rsp0_data,           64'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            check("oob_err_sticky", {63'd0, err}, 64'd1);
        end
        system1000_rst = 1'b1;
        #1;
        check("oob_err_reset", {63'd0, err}, 64'd0);
        next_cycle();
        system1000_rst = 1'b0;
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
